hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_pkg.sv | 23 ++
 rtl/hazard_controller_if.sv | 40 ++++
 rtl/hazard_controller_muldiv_busy_counter.sv | 25 ++
 rtl/hazard_controller.sv | 91 +++++++++
 tb/tb_hazard_controller.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared CPU constants for the hazard controller: FSM states, mul/div
// latency defaults and the hard-wired zero register.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_MULDIV_BUSY = 2'd1,
    ST_MEM_WAIT    = 2'd2
  } hz_state_t;

  localparam int unsigned MULT_CYCLES_DEF = 4;
  localparam int unsigned DIV_CYCLES_DEF  = 32;
  localparam int unsigned CNT_W           = 6;
  localparam logic [4:0]  REG_ZERO        = 5'd0;

  // A producer matches a consumer only if it targets a real register.
  function automatic logic reg_hit(input logic [4:0] dst,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt);
    return (dst != REG_ZERO) && ((dst == rs) || (dst == rt));
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle; names match the legacy ports.
interface hazard_controller_if;
  logic [4:0] rs_decode;
  logic [4:0] rt_decode;
  logic [4:0] write_reg_execute;
  logic       reg_write_execute;
  logic       mem_to_reg_execute;
  logic [4:0] write_reg_memory;
  logic       mem_to_reg_memory;
  logic       branch_decode;
  logic       branch_taken_decode;
  logic       hilo_read_decode;
  logic       muldiv_start_execute;
  logic       muldiv_is_div_execute;
  logic       mem_wait;
  logic       stall_fetch;
  logic       stall_decode;
  logic       flush_decode;
  logic       flush_execute;
  logic       freeze_back;
  logic       muldiv_busy;

  modport master (
    output rs_decode, rt_decode, write_reg_execute, reg_write_execute,
           mem_to_reg_execute, write_reg_memory, mem_to_reg_memory,
           branch_decode, branch_taken_decode, hilo_read_decode,
           muldiv_start_execute, muldiv_is_div_execute, mem_wait,
    input  stall_fetch, stall_decode, flush_decode, flush_execute,
           freeze_back, muldiv_busy
  );

  modport slave (
    input  rs_decode, rt_decode, write_reg_execute, reg_write_execute,
           mem_to_reg_execute, write_reg_memory, mem_to_reg_memory,
           branch_decode, branch_taken_decode, hilo_read_decode,
           muldiv_start_execute, muldiv_is_div_execute, mem_wait,
    output stall_fetch, stall_decode, flush_decode, flush_execute,
           freeze_back, muldiv_busy
  );
endinterface

// File: rtl/hazard_controller_muldiv_busy_counter.sv
// Occupancy counter for the multiply/divide unit: reload on start, count
// down to zero otherwise.
module muldiv_busy_counter
  import hazard_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (!zero)
      count <= count - CNT_W'(1);
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use, branch-operand and HI/LO stalls,
// memory-wait freeze and taken-branch flush for the 5-stage core.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  hazard_controller_if.slave  hz
);

  hz_state_t        state, state_nx;
  logic [CNT_W-1:0] busy_count;
  logic [CNT_W-1:0] load_value;
  logic             count_zero;
  logic             busy;
  logic             load_use, branch_hz, hilo_hz, hazard;

  assign load_value = hz.muldiv_is_div_execute ? CNT_W'(DIV_CYCLES)
                                               : CNT_W'(MULT_CYCLES);

  muldiv_busy_counter u_busy_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (hz.muldiv_start_execute),
    .load_value (load_value),
    .count      (busy_count),
    .zero       (count_zero)
  );

  assign busy = !count_zero || hz.muldiv_start_execute;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (hz.mem_wait)                  state_nx = ST_MEM_WAIT;
        else if (hz.muldiv_start_execute) state_nx = ST_MULDIV_BUSY;
      ST_MEM_WAIT:
        if (!hz.mem_wait)                 state_nx = count_zero ? ST_IDLE : ST_MULDIV_BUSY;
      ST_MULDIV_BUSY:
        if (hz.mem_wait)                  state_nx = ST_MEM_WAIT;
        else if (count_zero)              state_nx = ST_IDLE;
      default:                            state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  assign load_use  = hz.mem_to_reg_execute &&
                     reg_hit(hz.write_reg_execute, hz.rs_decode, hz.rt_decode);
  assign branch_hz = hz.branch_decode &&
                     ((hz.reg_write_execute &&
                       reg_hit(hz.write_reg_execute, hz.rs_decode, hz.rt_decode)) ||
                      (hz.mem_to_reg_memory &&
                       reg_hit(hz.write_reg_memory, hz.rs_decode, hz.rt_decode)));
  assign hilo_hz   = hz.hilo_read_decode && busy;
  assign hazard    = load_use || branch_hz || hilo_hz;

  // Priority: reset, then memory wait, then decode hazards; a taken branch
  // only flushes once nothing is holding Decode.
  always_comb begin
    hz.stall_fetch   = 1'b0;
    hz.stall_decode  = 1'b0;
    hz.flush_decode  = 1'b0;
    hz.flush_execute = 1'b0;
    hz.freeze_back   = 1'b0;
    hz.muldiv_busy   = busy;
    if (reset) begin
      hz.flush_decode  = 1'b1;
      hz.flush_execute = 1'b1;
      hz.muldiv_busy   = 1'b0;
    end else if (hz.mem_wait) begin
      hz.stall_fetch  = 1'b1;
      hz.stall_decode = 1'b1;
      hz.freeze_back  = 1'b1;
    end else if (hazard) begin
      hz.stall_fetch   = 1'b1;
      hz.stall_decode  = 1'b1;
      hz.flush_execute = 1'b1;
    end else begin
      hz.flush_decode = hz.branch_taken_decode;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scenarios plus randomized traffic checked against a cycle-level
// behavioural model of the hazard rules.
module tb_hazard_controller;

  localparam int MULT_C = 4;
  localparam int DIV_C  = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_controller_if hif ();

  hazard_controller #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_start = 0;
  int   dur = 0;
  bit   have_start = 1'b0;
  logic [5:0] last_obs;

  function automatic bit hit(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    return (d != 0) && (d == a || d == b);
  endfunction

  task automatic clear_inputs();
    hif.rs_decode = 0; hif.rt_decode = 0;
    hif.write_reg_execute = 0; hif.reg_write_execute = 0; hif.mem_to_reg_execute = 0;
    hif.write_reg_memory = 0; hif.mem_to_reg_memory = 0;
    hif.branch_decode = 0; hif.branch_taken_decode = 0; hif.hilo_read_decode = 0;
    hif.muldiv_start_execute = 0; hif.muldiv_is_div_execute = 0; hif.mem_wait = 0;
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Check the current cycle's outputs, then advance one clock.
  task automatic step(input string tag);
    logic [5:0] exp_v, obs_v;
    bit busy, hzd;
    #1;
    busy = hif.muldiv_start_execute || (have_start && (cyc - last_start <= dur));
    hzd  = (hif.mem_to_reg_execute && hit(hif.write_reg_execute, hif.rs_decode, hif.rt_decode))
        || (hif.branch_decode &&
            ((hif.reg_write_execute && hit(hif.write_reg_execute, hif.rs_decode, hif.rt_decode))
          || (hif.mem_to_reg_memory && hit(hif.write_reg_memory, hif.rs_decode, hif.rt_decode))))
        || (hif.hilo_read_decode && busy);
    // bit order: stall_fetch stall_decode flush_decode flush_execute freeze_back muldiv_busy
    if (reset)             exp_v = 6'b001100;
    else if (hif.mem_wait) exp_v = {5'b11001, busy};
    else if (hzd)          exp_v = {5'b11010, busy};
    else                   exp_v = {2'b00, hif.branch_taken_decode, 2'b00, busy};
    obs_v = {hif.stall_fetch, hif.stall_decode, hif.flush_decode,
             hif.flush_execute, hif.freeze_back, hif.muldiv_busy};
    last_obs = obs_v;
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s cycle=%0d got=%b want=%b", tag, cyc, obs_v, exp_v);
    end
    @(posedge clk);
    if (reset) have_start = 1'b0;
    else if (hif.muldiv_start_execute) begin
      have_start = 1'b1;
      last_start = cyc;
      dur = hif.muldiv_is_div_execute ? DIV_C : MULT_C;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    step("reset0");
    step("reset1");
    reset = 1'b0;
    step("idle");

    // load-use: lw $8 in Execute, add reading $8 in Decode
    hif.mem_to_reg_execute = 1; hif.reg_write_execute = 1; hif.write_reg_execute = 8;
    hif.rs_decode = 8; hif.rt_decode = 3;
    step("loaduse_stall");
    chk_int("loaduse_stall_fetch", int'(last_obs[5]), 1);
    clear_inputs();
    hif.mem_to_reg_memory = 1; hif.write_reg_memory = 8; hif.rs_decode = 8; hif.rt_decode = 3;
    step("loaduse_release");
    chk_int("loaduse_release_stall", int'(last_obs[5]), 0);

    // branch on $9 with add producer in Execute, then with a load in Memory
    clear_inputs();
    hif.branch_decode = 1; hif.rs_decode = 9; hif.rt_decode = 0;
    hif.reg_write_execute = 1; hif.write_reg_execute = 9;
    step("br_alu");
    hif.reg_write_execute = 0; hif.write_reg_execute = 0;
    step("br_alu_release");
    hif.mem_to_reg_execute = 1; hif.reg_write_execute = 1; hif.write_reg_execute = 9;
    step("br_load_ex");
    hif.mem_to_reg_execute = 0; hif.reg_write_execute = 0; hif.write_reg_execute = 0;
    hif.mem_to_reg_memory = 1; hif.write_reg_memory = 9;
    step("br_load_mem");
    chk_int("br_load_mem_stall", int'(last_obs[5]), 1);
    clear_inputs();
    hif.branch_decode = 1; hif.branch_taken_decode = 1; hif.rs_decode = 9;
    step("br_taken");
    chk_int("br_taken_flush", int'(last_obs[3]), 1);

    // DIV then MFLO: stall count equals divider latency
    clear_inputs();
    hif.muldiv_start_execute = 1; hif.muldiv_is_div_execute = 1;
    step("div_start");
    clear_inputs();
    hif.hilo_read_decode = 1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step("mflo_wait");
      if (!last_obs[5]) break;
      chk_int("mflo_busy_flag", int'(last_obs[0]), 1);
      n++;
    end
    chk_int("mflo_stall_cycles", n, DIV_C);

    // mem_wait over load-use + taken branch
    clear_inputs();
    hif.mem_to_reg_execute = 1; hif.write_reg_execute = 5; hif.rt_decode = 5;
    hif.branch_taken_decode = 1; hif.mem_wait = 1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step("memwait");
      if (last_obs[1] && !last_obs[3] && !last_obs[2]) n++;
    end
    chk_int("memwait_freeze_cycles", n, 3);
    hif.mem_wait = 0;
    step("memwait_loaduse");
    hif.mem_to_reg_execute = 0; hif.write_reg_execute = 0;
    step("memwait_flush");
    chk_int("memwait_flush_decode", int'(last_obs[3]), 1);

    // reset in the middle of a divide (busy_count = 20)
    clear_inputs();
    hif.muldiv_start_execute = 1; hif.muldiv_is_div_execute = 1;
    step("div2_start");
    clear_inputs();
    for (int i = 0; i < 12; i++) step("div2_run");
    reset = 1'b1;
    step("div2_reset");
    reset = 1'b0;
    step("div2_after");
    chk_int("div2_after_busy", int'(last_obs[0]), 0);
    hif.mem_to_reg_execute = 1; hif.write_reg_execute = 0; hif.rs_decode = 0;
    step("lw_r0");
    chk_int("lw_r0_stall", int'(last_obs[5]), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      hif.rs_decode = 5'($urandom_range(0, 3));
      hif.rt_decode = 5'($urandom_range(0, 3));
      hif.write_reg_execute = 5'($urandom_range(0, 3));
      hif.write_reg_memory = 5'($urandom_range(0, 3));
      hif.reg_write_execute = 1'($urandom_range(0, 1));
      hif.mem_to_reg_execute = ($urandom_range(0, 3) == 0);
      hif.mem_to_reg_memory = ($urandom_range(0, 3) == 0);
      hif.branch_decode = ($urandom_range(0, 2) == 0);
      hif.branch_taken_decode = ($urandom_range(0, 2) == 0);
      hif.hilo_read_decode = ($urandom_range(0, 2) == 0);
      hif.muldiv_start_execute = ($urandom_range(0, 11) == 0);
      hif.muldiv_is_div_execute = 1'($urandom_range(0, 1));
      hif.mem_wait = ($urandom_range(0, 5) == 0);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
